square_calc: RTL and testbench
==============================

Name: square_calc

Overview:
Sequential integer squarer. It is the inverse of the square-root datapath/control pair. It accepts an unsigned root and produces root² by summing the first N odd numbers: 1 + 3 + 5 + … + (2N−1). This is the same odd-increment recurrence the root extractor consumes, so the block is used to generate reference squares and self-check the sqrt unit in loopback. Control FSM and datapath (accumulator, odd-term register, down-counter, adders) live in one module with a start/done handshake.

Parameters:
ROOT_WIDTH, 8, width of root_i. Square width is 2*ROOT_WIDTH; odd-term register width is ROOT_WIDTH+1.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start_i  input  1  request pulse/level; sampled only in IDLE
root_i  input  ROOT_WIDTH  unsigned operand; captured on the edge that accepts start_i
square_o  output  2*ROOT_WIDTH  result; holds the last completed square
busy_o  output  1  high while in CALC or DONE
done_o  output  1  one-cycle completion strobe

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, odd=1, count=0, square_o=0, busy_o=0, done_o=0. Reset dominates at any time. If asserted mid-calculation, the operation is abandoned and no done_o is produced.
- The clock and reset port names and polarity are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- State IDLE:
  - busy_o=0, done_o=0.
  - If start_i=1 at a rising edge: count<=root_i, acc<=0, odd<=1, go to CALC.
  - Else stay in IDLE.
- State CALC:
  - busy_o=1.
  - If count==0: square_o<=acc, go to DONE.
  - Else: acc<=acc+odd (zero-extended to 2*ROOT_WIDTH), odd<=odd+2, count<=count−1.
  - Adds are modulo-free: max acc = (2^ROOT_WIDTH−1)² fits 2*ROOT_WIDTH bits. Max odd after the final increment is 2^(ROOT_WIDTH+1)−1, which fits ROOT_WIDTH+1 bits. No overflow is possible and no carry-out is exported.
- State DONE:
  - done_o=1, busy_o=1 for exactly one cycle.
  - Unconditionally return to IDLE.
- Latency: let edge E0 be the edge that accepts start_i with root N. Then:
  - square_o updates on edge E0+N+1.
  - done_o is high for the cycle following E0+N+1.
  - Next start is accepted no earlier than edge E0+N+3.
  - Boundary values: N=0 gives done after 1 edge; N=2^ROOT_WIDTH−1 gives done after 2^ROOT_WIDTH edges.
- start_i asserted in CALC or DONE is ignored, neither queued nor restarting. root_i changes after capture have no effect.
- A start_i held high continuously gives back-to-back operations: each returns through IDLE, so there is one idle cycle between done_o and the next capture.
- square_o changes only on CALC→DONE or reset; it is stable in IDLE and while a new calculation runs.
- The FSM encoding is 2-bit. The unused code returns to IDLE on the next edge with all outputs low.

Test Plan:
- Reset, then start_i=1 for one cycle with root_i=0 → done_o pulses 1 edge later, square_o=0, busy_o high for 2 cycles.
- root_i=15 → square_o=225 on edge E0+16, done_o high for exactly one cycle, busy_o falls the following cycle.
- root_i=255 (ROOT_WIDTH=8) → square_o=65025 (0xFE01) after 256 edges, no overflow; then root_i=1 → square_o=1.
- Start with root_i=10, pulse start_i again with root_i=3 during CALC → ignored; single done_o with square_o=100.
- Assert rst_n=0 asynchronously mid-way through root_i=200 → outputs 0 immediately, no done_o; after release, root_i=7 → 49.
- Sweep all roots 0..255, each result compared with root*root, and in loopback fed to the sqrt unit → returned root equals the input root.

Source files
------------

// File: rtl/square_calc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// square_calc
// Sequential integer squarer. The square of N is built as the sum of the
// first N odd numbers, 1 + 3 + ... + (2N-1). The root extractor consumes the
// same odd-increment sequence, so this block can produce reference squares
// for a loopback self-check of the sqrt unit.
//
// Ports
//   clk       : system clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   start_i   : request; sampled only while idle
//   root_i    : unsigned operand, captured on the edge that accepts start_i
//   square_o  : last completed square (2*ROOT_WIDTH bits), registered
//   busy_o    : high while calculating or signalling completion, registered
//   done_o    : one-cycle completion strobe, registered
// -----------------------------------------------------------------------------
module square_calc #(
   parameter int ROOT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [ROOT_WIDTH-1:0]     root_i,
   output logic [2*ROOT_WIDTH-1:0]   square_o,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int SQ_W  = 2 * ROOT_WIDTH;
   // The odd term reaches 2N+1 after the last add, which needs one extra bit.
   localparam int ODD_W = ROOT_WIDTH + 1;

   localparam logic [ODD_W-1:0]      ODD_ONE  = ODD_W'(1);
   localparam logic [ODD_W-1:0]      ODD_TWO  = ODD_W'(2);
   localparam logic [ROOT_WIDTH-1:0] CNT_ZERO = {ROOT_WIDTH{1'b0}};
   localparam logic [ROOT_WIDTH-1:0] CNT_ONE  = ROOT_WIDTH'(1);
   localparam logic [SQ_W-1:0]       SQ_ZERO  = {SQ_W{1'b0}};

   // The fourth code is never entered deliberately; it only recovers to idle.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_CALC   = 2'b01,
      ST_DONE   = 2'b10,
      ST_UNUSED = 2'b11
   } state_t;

   state_t                state_q,  state_d;
   logic [SQ_W-1:0]       acc_q,    acc_d;
   logic [ODD_W-1:0]      odd_q,    odd_d;
   logic [ROOT_WIDTH-1:0] count_q,  count_d;
   logic [SQ_W-1:0]       square_q, square_d;
   logic                  busy_q,   busy_d;
   logic                  done_q,   done_d;

   // Next-state and datapath update for the control FSM.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      odd_d    = odd_q;
      count_d  = count_q;
      square_d = square_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               count_d = root_i;
               acc_d   = SQ_ZERO;
               odd_d   = ODD_ONE;
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (count_q == CNT_ZERO) begin
               // Result is published only here, so square_o stays stable
               // through idle and through the next calculation.
               square_d = acc_q;
               state_d  = ST_DONE;
            end else begin
               acc_d   = acc_q + SQ_W'(odd_q);
               odd_d   = odd_q + ODD_TWO;
               count_d = count_q - CNT_ONE;
               state_d = ST_CALC;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status outputs are decoded from the next state so they register
      // in step with the state they describe.
      busy_d = (state_d == ST_CALC) || (state_d == ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= SQ_ZERO;
         odd_q    <= ODD_ONE;
         count_q  <= CNT_ZERO;
         square_q <= SQ_ZERO;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         odd_q    <= odd_d;
         count_q  <= count_d;
         square_q <= square_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign square_o = square_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_square_calc.sv
`timescale 1ns/1ps
module tb_square_calc;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [7:0]  root_i;
   logic [15:0] square_o;
   logic        busy_o;
   logic        done_o;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int root;
      int sq;
   } exp_t;
   exp_t exp_q[$];

   square_calc #(.ROOT_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .root_i   (root_i),
      .square_o (square_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int want);
      n_total++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, want);
   endtask

   // Behavioural square root used as the loopback partner.
   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Scoreboard monitor: every completion strobe must match the oldest request.
   always @(negedge clk) begin
      if (done_o) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("square_root%0d", e.root), int'(square_o), e.sq);
            chk($sformatf("loopback_root%0d", e.root), isqrt(int'(square_o)), e.root);
         end
      end
   end

   // Wait for done_o after posedge+#1 sampling; returns edges since capture.
   task automatic wait_done(input int limit, input int ign_at, output int edges);
      edges = 0;
      while (!done_o && edges < limit) begin
         @(posedge clk); #1;
         edges++;
         if (edges == ign_at) begin
            start_i = 1'b1;
            root_i  = 8'd3;
         end else begin
            start_i = 1'b0;
            root_i  = 8'($urandom);
         end
      end
      start_i = 1'b0;
   endtask

   // One complete operation; ign_at>0 pulses a start during CALC at that edge.
   task automatic run_op(input int n, input int ign_at);
      int edges;
      logic [15:0] prev;
      @(negedge clk);
      prev    = square_o;
      start_i = 1'b1;
      root_i  = n[7:0];
      exp_q.push_back('{n, n * n});
      @(posedge clk); #1;
      start_i = 1'b0;
      root_i  = 8'($urandom);
      chk("busy_on_accept", int'(busy_o), 1);
      chk("square_hold", int'(square_o), int'(prev));
      wait_done(300, ign_at, edges);
      chk($sformatf("done_latency_root%0d", n), edges, n + 1);
      chk("busy_with_done", int'(busy_o), 1);
      @(posedge clk); #1;
      chk("done_width", int'(done_o), 0);
      chk("busy_fall", int'(busy_o), 0);
   endtask

   initial begin
      int edges;
      rst_n   = 1'b0;
      start_i = 1'b0;
      root_i  = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_square", int'(square_o), 0);
      chk("reset_busy", int'(busy_o), 0);
      chk("reset_done", int'(done_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed boundaries and main cases.
      run_op(0, 0);
      run_op(15, 0);
      run_op(255, 0);
      run_op(1, 0);
      run_op(10, 4);

      // start_i held high: one idle cycle between done and next capture.
      @(negedge clk);
      start_i = 1'b1;
      root_i  = 8'd5;
      exp_q.push_back('{5, 25});
      @(posedge clk); #1;
      wait_done(300, -1, edges);
      start_i = 1'b1;
      chk("held_latency_first", edges, 6);
      root_i = 8'd6;
      exp_q.push_back('{6, 36});
      @(posedge clk); #1;
      chk("held_idle_gap", int'(busy_o), 0);
      @(posedge clk); #1;
      chk("held_recapture", int'(busy_o), 1);
      start_i = 1'b0;
      wait_done(300, -1, edges);
      chk("held_latency_second", edges, 7);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a long calculation.
      run_op(9, 0);
      @(negedge clk);
      start_i = 1'b1;
      root_i  = 8'd200;
      exp_q.push_back('{200, 40000});
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (50) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_square", int'(square_o), 0);
      chk("async_rst_busy", int'(busy_o), 0);
      chk("async_rst_done", int'(done_o), 0);
      exp_q.delete();
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      chk("no_done_after_abort", int'(busy_o), 0);
      run_op(7, 0);

      // Randomized operations with stray starts during CALC.
      for (int i = 0; i < 20; i++) begin
         int r;
         r = int'($urandom_range(0, 255));
         run_op(r, (r > 2) ? int'($urandom_range(1, r)) : 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Full sweep with loopback through the behavioural sqrt.
      for (int r = 0; r < 256; r++) begin
         run_op(r, 0);
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule
